uart_board_ctrl: RTL and testbench
==================================

Name: uart_board_ctrl

Overview:
- Parametrised front-panel controller for the UART tester board.
- Debounces N_BTN push-buttons. Button 0 requests a transmit; buttons 1..N_BTN-1 flip mode bits such as stop-bit size, data size and parity enable.
- Adds a pending-send handshake against the transmitter and a timed auto-repeat send mode.
- Captures received bytes and counts frames in both directions for the seven-segment display.

Parameters:
- DATA_W, 8, width of the transmit/receive data path.
- N_BTN, 3, number of buttons. Index 0 is send; indices 1..N_BTN-1 are toggles. Minimum 2.
- DEB_CYCLES, 100000, consecutive stable samples required before a debounced level changes. Minimum 2.
- REPEAT_CYCLES, 50000000, auto-send period in clk cycles. Minimum 2.
- CNT_W, 8, width of the tx/rx frame counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- btn  in  N_BTN  raw asynchronous button inputs
- auto_sw  in  1  level switch; 1 = auto-repeat send enabled
- sw  in  DATA_W  transmit data source
- tx_ready  in  1  transmitter idle, can accept a frame
- rx_valid  in  1  one-cycle strobe, new received frame on rx_data
- rx_data  in  DATA_W  received frame
- send  out  1  one-cycle transmit strobe
- data_i  out  DATA_W  frame presented to transmitter, stable from send until the next send
- mode  out  N_BTN-1  toggle bits; mode[k] is driven by btn[k+1]
- pending  out  1  a send request is waiting for tx_ready
- rx_hold  out  DATA_W  last received frame
- tx_cnt  out  CNT_W  frames sent, modulo 2^CNT_W
- rx_cnt  out  CNT_W  frames received, modulo 2^CNT_W

Behaviour:
- Reset: rst is synchronous and active-high; all state is cleared on the clk edge where rst=1.
  - send, data_i, mode, pending, rx_hold, tx_cnt, rx_cnt, the auto period counter and all debounce counters = 0.
  - Synchronisers and debounced levels = 0.
  - Reset asserted mid-operation aborts any pending or auto send with no send strobe.
- Synchronisation: each btn bit and auto_sw pass through a 2-flop synchroniser.
- Debounce, per button:
  - Counter resets whenever the synchronised input equals the debounced level.
  - Otherwise the counter increments. On reaching DEB_CYCLES-1 the debounced level flips and the counter clears.
  - A glitch shorter than DEB_CYCLES cycles never changes the level.
- Press pulse: one-cycle pulse on each 0->1 transition of a debounced level. Release produces nothing.
- Toggles: mode[k] <= mode[k] ^ press[k+1], taking effect the cycle after the pulse. Simultaneous presses on several buttons each act independently.
- Send request: press[0], or an auto tick, sets an internal request.
- Send state machine, states IDLE and WAIT:
  - IDLE, request and tx_ready=1: send=1 for one cycle, data_i<=sw sampled that cycle, tx_cnt++. Stay IDLE.
  - IDLE, request and tx_ready=0: go to WAIT, pending=1.
  - WAIT, tx_ready=1: send=1, data_i<=current sw, tx_cnt++, pending=0, return to IDLE.
  - WAIT, further requests: absorbed; at most one send is outstanding.
  - Latency from press pulse to send with tx_ready=1: 1 cycle.
  - send is never asserted on two consecutive cycles. The cycle after send is treated as not ready regardless of tx_ready, which guards against tx_ready lagging the transmitter.
- Auto mode:
  - While the synchronised auto_sw=1, the period counter counts 0..REPEAT_CYCLES-1 and wraps.
  - Wrap generates an auto tick (a request).
  - auto_sw=0 holds the counter at 0. Re-enabling starts a full period, so the first auto send comes REPEAT_CYCLES cycles later.
  - Manual press and auto tick in the same cycle merge into one send.
- Receive: on rx_valid, rx_hold<=rx_data and rx_cnt++ on the next edge. The path is independent of the send FSM; simultaneous rx_valid and send both complete.
- Counters wrap: at 2^CNT_W-1 an increment gives 0.

Test Plan:
- Sim with DEB_CYCLES=4, REPEAT_CYCLES=20.
- Bounce: btn[1] pulses high for 2 cycles three times, then is held high for 10 cycles -> mode[0] toggles exactly once (0->1). A second clean press -> mode[0]=0. Releases cause no change.
- Send ready: sw=8'hA5, tx_ready=1, press btn[0] -> single send pulse one cycle after the debounced edge, data_i=8'hA5, tx_cnt=1, pending stays 0.
- Send blocked: tx_ready=0, sw=8'h3C, press btn[0] twice -> pending=1, no send. Change sw=8'h7E, then raise tx_ready -> exactly one send, data_i=8'h7E, pending=0, tx_cnt +1.
- Auto: auto_sw=1, tx_ready=1, run 100 cycles -> sends at 20-cycle intervals, first about 20 cycles after the synchronised enable. Clear auto_sw -> no further sends.
- Receive and wrap: CNT_W=8, preload via 255 rx_valid strobes, then rx_valid with rx_data=8'h42 -> rx_hold=8'h42, rx_cnt=0. Simultaneous rx_valid and send both counted.
- Reset mid-WAIT: pending=1, assert rst for 1 cycle -> all outputs 0, no send when tx_ready later rises.

Source files
------------

// File: rtl/uart_board_ctrl.sv
// Front-panel controller for the UART tester board: debounced buttons, mode toggles,
// send handshake with auto-repeat, and receive capture with frame counters.
module uart_board_ctrl #(
  parameter int DATA_W        = 8,
  parameter int N_BTN         = 3,
  parameter int DEB_CYCLES    = 100000,
  parameter int REPEAT_CYCLES = 50000000,
  parameter int CNT_W         = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BTN-1:0]  btn,
  input  logic              auto_sw,
  input  logic [DATA_W-1:0] sw,
  input  logic              tx_ready,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              send,
  output logic [DATA_W-1:0] data_i,
  output logic [N_BTN-2:0]  mode,
  output logic              pending,
  output logic [DATA_W-1:0] rx_hold,
  output logic [CNT_W-1:0]  tx_cnt,
  output logic [CNT_W-1:0]  rx_cnt
);

  localparam int DW = $clog2(DEB_CYCLES);
  localparam int RW = $clog2(REPEAT_CYCLES);

  localparam logic [DW-1:0]    DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [DW-1:0]    DEB_ONE  = DW'(1);
  localparam logic [DW-1:0]    DEB_ZERO = DW'(0);
  localparam logic [RW-1:0]    PER_LAST = RW'(REPEAT_CYCLES - 1);
  localparam logic [RW-1:0]    PER_ONE  = RW'(1);
  localparam logic [RW-1:0]    PER_ZERO = RW'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  logic [N_BTN-1:0] btn_meta_r;
  logic [N_BTN-1:0] btn_sync_r;
  logic [N_BTN-1:0] deb_lvl_r;
  logic [N_BTN-1:0] press_r;
  logic [DW-1:0]    deb_cnt_r [N_BTN];

  logic             auto_meta_r;
  logic             auto_sync_r;
  logic             auto_tick_r;
  logic [RW-1:0]    per_cnt_r;

  state_t           state_r;
  logic             req_s;
  logic             ready_s;

  // Button synchronisers, per-button debounce counters and rising-edge press pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta_r <= {N_BTN{1'b0}};
      btn_sync_r <= {N_BTN{1'b0}};
      deb_lvl_r  <= {N_BTN{1'b0}};
      press_r    <= {N_BTN{1'b0}};
      for (int i = 0; i < N_BTN; i++) begin
        deb_cnt_r[i] <= DEB_ZERO;
      end
    end else begin
      btn_meta_r <= btn;
      btn_sync_r <= btn_meta_r;
      for (int i = 0; i < N_BTN; i++) begin
        if (btn_sync_r[i] == deb_lvl_r[i]) begin
          deb_cnt_r[i] <= DEB_ZERO;
          press_r[i]   <= 1'b0;
        end else if (deb_cnt_r[i] == DEB_LAST) begin
          deb_lvl_r[i] <= ~deb_lvl_r[i];
          deb_cnt_r[i] <= DEB_ZERO;
          press_r[i]   <= ~deb_lvl_r[i];
        end else begin
          deb_cnt_r[i] <= deb_cnt_r[i] + DEB_ONE;
          press_r[i]   <= 1'b0;
        end
      end
    end
  end

  // Mode bits flip on each press of their toggle button
  always_ff @(posedge clk) begin
    if (rst) begin
      mode <= {(N_BTN-1){1'b0}};
    end else begin
      mode <= mode ^ press_r[N_BTN-1:1];
    end
  end

  // Auto-repeat period counter; held at zero while disabled so re-enable gets a full period
  always_ff @(posedge clk) begin
    if (rst) begin
      auto_meta_r <= 1'b0;
      auto_sync_r <= 1'b0;
      per_cnt_r   <= PER_ZERO;
      auto_tick_r <= 1'b0;
    end else begin
      auto_meta_r <= auto_sw;
      auto_sync_r <= auto_meta_r;
      if (auto_sync_r) begin
        if (per_cnt_r == PER_LAST) begin
          per_cnt_r   <= PER_ZERO;
          auto_tick_r <= 1'b1;
        end else begin
          per_cnt_r   <= per_cnt_r + PER_ONE;
          auto_tick_r <= 1'b0;
        end
      end else begin
        per_cnt_r   <= PER_ZERO;
        auto_tick_r <= 1'b0;
      end
    end
  end

  // The cycle after a send is treated as busy in case tx_ready lags the transmitter
  always_comb begin
    req_s   = press_r[0] | auto_tick_r;
    ready_s = tx_ready & ~send;
  end

  // Send state machine: at most one request outstanding while waiting for tx_ready
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      send    <= 1'b0;
      pending <= 1'b0;
      data_i  <= {DATA_W{1'b0}};
      tx_cnt  <= CNT_ZERO;
    end else begin
      send <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_s) begin
            if (ready_s) begin
              send   <= 1'b1;
              data_i <= sw;
              tx_cnt <= tx_cnt + CNT_ONE;
            end else begin
              state_r <= WAIT;
              pending <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (ready_s) begin
            send    <= 1'b1;
            data_i  <= sw;
            tx_cnt  <= tx_cnt + CNT_ONE;
            pending <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          pending <= 1'b0;
        end
      endcase
    end
  end

  // Receive capture, independent of the send path
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_hold <= {DATA_W{1'b0}};
      rx_cnt  <= CNT_ZERO;
    end else if (rx_valid) begin
      rx_hold <= rx_data;
      rx_cnt  <= rx_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_uart_board_ctrl.sv
// Directed bench for uart_board_ctrl with short debounce and repeat periods.
module tb_uart_board_ctrl;

  logic       clk;
  logic       rst;
  logic [2:0] btn;
  logic       auto_sw;
  logic [7:0] sw;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       send;
  logic [7:0] data_i;
  logic [1:0] mode;
  logic       pending;
  logic [7:0] rx_hold;
  logic [7:0] tx_cnt;
  logic [7:0] rx_cnt;

  int checks;
  int failures;
  int send_seen;
  int base;

  uart_board_ctrl #(
    .DATA_W(8), .N_BTN(3), .DEB_CYCLES(4), .REPEAT_CYCLES(20), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn), .auto_sw(auto_sw), .sw(sw),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
    .send(send), .data_i(data_i), .mode(mode), .pending(pending),
    .rx_hold(rx_hold), .tx_cnt(tx_cnt), .rx_cnt(rx_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (send) send_seen <= send_seen + 1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input int idx, input int hold, input int settle);
    btn[idx] = 1'b1;
    step(hold);
    btn[idx] = 1'b0;
    step(settle);
  endtask

  initial begin
    checks = 0; failures = 0; send_seen = 0;
    rst = 1'b1; btn = 3'b000; auto_sw = 1'b0; sw = 8'h00;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    step(3);
    rst = 1'b0;
    chk("rst_send", 32'(send), 32'd0);
    chk("rst_data_i", 32'(data_i), 32'd0);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_tx_cnt", 32'(tx_cnt), 32'd0);
    chk("rst_rx_cnt", 32'(rx_cnt), 32'd0);
    chk("rst_rx_hold", 32'(rx_hold), 32'd0);

    // Bounce on btn[1]: three 2-cycle glitches, then a 10-cycle hold
    for (int i = 0; i < 3; i++) begin
      press(1, 2, 2);
      chk("bounce_glitch", 32'(mode), 32'd0);
    end
    press(1, 10, 12);
    chk("bounce_once", 32'(mode), 32'd1);
    press(1, 10, 12);
    chk("second_press", 32'(mode), 32'd0);
    step(10);
    chk("release_quiet", 32'(mode), 32'd0);

    // Send with transmitter ready
    sw = 8'hA5; tx_ready = 1'b1;
    btn[0] = 1'b1;
    step(6);
    chk("send_early", 32'(send), 32'd0);
    step(1);
    chk("send_pulse", 32'(send), 32'd1);
    chk("send_data", 32'(data_i), 32'hA5);
    chk("send_tx_cnt", 32'(tx_cnt), 32'd1);
    chk("send_pending", 32'(pending), 32'd0);
    step(1);
    chk("send_single", 32'(send), 32'd0);
    btn[0] = 1'b0;
    step(10);
    chk("send_count", 32'(send_seen), 32'd1);

    // Send blocked: two presses absorbed into one pending send
    tx_ready = 1'b0; sw = 8'h3C;
    press(0, 8, 8);
    press(0, 8, 8);
    chk("blocked_pending", 32'(pending), 32'd1);
    chk("blocked_nosend", 32'(send_seen), 32'd1);
    sw = 8'h7E; tx_ready = 1'b1;
    step(1);
    chk("release_send", 32'(send), 32'd1);
    chk("release_data", 32'(data_i), 32'h7E);
    chk("release_pending", 32'(pending), 32'd0);
    chk("release_tx_cnt", 32'(tx_cnt), 32'd2);
    step(10);
    chk("release_count", 32'(send_seen), 32'd2);

    // Auto-repeat: sends expected 23, 43, 63, 83 cycles after auto_sw rises
    base = send_seen;
    auto_sw = 1'b1;
    step(22);
    chk("auto_not_yet", 32'(send), 32'd0);
    step(1);
    chk("auto_first", 32'(send), 32'd1);
    step(19);
    chk("auto_gap", 32'(send), 32'd0);
    step(1);
    chk("auto_second", 32'(send), 32'd1);
    step(47);
    chk("auto_count", 32'(send_seen - base), 32'd4);
    auto_sw = 1'b0;
    step(40);
    chk("auto_stopped", 32'(send_seen - base), 32'd4);
    chk("auto_tx_cnt", 32'(tx_cnt), 32'd6);

    // Receive wrap together with a simultaneous send
    rx_valid = 1'b1;
    for (int i = 0; i < 255; i++) begin
      rx_data = 8'(i);
      step(1);
    end
    rx_valid = 1'b0;
    chk("rx_preload_cnt", 32'(rx_cnt), 32'd255);
    chk("rx_preload_hold", 32'(rx_hold), 32'hFE);
    btn[0] = 1'b1;
    step(6);
    rx_valid = 1'b1; rx_data = 8'h42;
    step(1);
    rx_valid = 1'b0;
    chk("rx_hold", 32'(rx_hold), 32'h42);
    chk("rx_wrap", 32'(rx_cnt), 32'd0);
    chk("simul_send", 32'(send), 32'd1);
    chk("simul_tx_cnt", 32'(tx_cnt), 32'd7);
    btn[0] = 1'b0;
    step(10);

    // Reset while a send is pending
    press(2, 8, 8);
    chk("mode_bit1", 32'(mode), 32'd2);
    tx_ready = 1'b0;
    press(0, 8, 8);
    chk("wait_pending", 32'(pending), 32'd1);
    base = send_seen;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("mid_rst_send", 32'(send), 32'd0);
    chk("mid_rst_pending", 32'(pending), 32'd0);
    chk("mid_rst_mode", 32'(mode), 32'd0);
    chk("mid_rst_data_i", 32'(data_i), 32'd0);
    chk("mid_rst_tx_cnt", 32'(tx_cnt), 32'd0);
    chk("mid_rst_rx_cnt", 32'(rx_cnt), 32'd0);
    chk("mid_rst_rx_hold", 32'(rx_hold), 32'd0);
    tx_ready = 1'b1;
    step(10);
    chk("mid_rst_nosend", 32'(send_seen - base), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
